// File: rtl/logo_anim_ctrl.sv
// Frame-synchronous logo animation sequencer: reveals letters one by one, scrolls the
// logo right, holds, scrolls back, and merges the enabled letter hits into one pixel flag.
module logo_anim_ctrl #(
    parameter int NUM_LETTERS   = 4,
    parameter int STEP          = 2,
    parameter int DELT_MAX      = 600,
    parameter int REVEAL_FRAMES = 15,
    parameter int HOLD_FRAMES   = 120
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   vsync,
    input  logic [NUM_LETTERS-1:0] hit_in,
    output logic [10:0]            delt,
    output logic [NUM_LETTERS-1:0] letter_en,
    output logic                   logo_hit,
    output logic                   busy
);

    localparam int FCNT_MAX = (REVEAL_FRAMES > HOLD_FRAMES) ? REVEAL_FRAMES : HOLD_FRAMES;
    localparam int FCNT_W   = (FCNT_MAX < 2) ? 1 : $clog2(FCNT_MAX);

    localparam logic [FCNT_W-1:0]      REV_LAST  = FCNT_W'(REVEAL_FRAMES - 1);
    localparam logic [FCNT_W-1:0]      HOLD_LAST = FCNT_W'(HOLD_FRAMES - 1);
    localparam logic [11:0]            STEP_12   = 12'(STEP);
    localparam logic [11:0]            DMAX_12   = 12'(DELT_MAX);
    localparam logic [10:0]            STEP_11   = 11'(STEP);
    localparam logic [10:0]            DMAX_11   = 11'(DELT_MAX);
    localparam logic [NUM_LETTERS-1:0] ALL_ON    = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REVEAL,
        ST_SCROLL,
        ST_HOLD,
        ST_RETURN
    } state_t;

    state_t                   state, state_d;
    logic [10:0]              delt_d;
    logic [NUM_LETTERS-1:0]   en_d, en_shift;
    logic [FCNT_W-1:0]        fcnt, fcnt_d;
    logic [11:0]              delt_sum;
    logic                     vsync_q, armed, frame_tick;

    // armed stays low until vsync has been seen low, so a vsync level held across reset
    // release cannot be mistaken for a rising edge
    assign frame_tick = vsync & ~vsync_q & armed;
    assign busy       = (state != ST_IDLE);
    assign delt_sum   = {1'b0, delt} + STEP_12;
    assign en_shift   = NUM_LETTERS'({letter_en, 1'b1});

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            delt      <= '0;
            letter_en <= '0;
            fcnt      <= '0;
            logo_hit  <= 1'b0;
            vsync_q   <= 1'b0;
            armed     <= ~vsync;
        end else begin
            state     <= state_d;
            delt      <= delt_d;
            letter_en <= en_d;
            fcnt      <= fcnt_d;
            logo_hit  <= |(hit_in & letter_en);
            vsync_q   <= vsync;
            armed     <= armed | ~vsync;
        end
    end

    always_comb begin
        state_d = state;
        delt_d  = delt;
        en_d    = letter_en;
        fcnt_d  = fcnt;
        if (frame_tick) begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state_d = ST_REVEAL;
                        en_d    = NUM_LETTERS'(1);
                        fcnt_d  = '0;
                    end
                end
                ST_REVEAL: begin
                    if (!run) begin
                        state_d = ST_RETURN;
                    end else if (fcnt == REV_LAST) begin
                        fcnt_d = '0;
                        en_d   = en_shift;
                        if (en_shift == ALL_ON) state_d = ST_SCROLL;
                    end else begin
                        fcnt_d = fcnt + FCNT_W'(1);
                    end
                end
                ST_SCROLL: begin
                    if (!run) begin
                        state_d = ST_RETURN;
                    end else if (delt_sum >= DMAX_12) begin
                        delt_d  = DMAX_11;
                        fcnt_d  = '0;
                        state_d = ST_HOLD;
                    end else begin
                        delt_d = delt_sum[10:0];
                    end
                end
                ST_HOLD: begin
                    if (!run) begin
                        state_d = ST_RETURN;
                    end else if (fcnt == HOLD_LAST) begin
                        fcnt_d  = '0;
                        state_d = ST_RETURN;
                    end else begin
                        fcnt_d = fcnt + FCNT_W'(1);
                    end
                end
                ST_RETURN: begin
                    // run is ignored here: the scroll back always completes
                    if ({1'b0, delt} <= STEP_12) begin
                        delt_d  = '0;
                        en_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        delt_d = delt - STEP_11;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    delt_d  = '0;
                    en_d    = '0;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logo_anim_ctrl.sv
// Bench for logo_anim_ctrl: expected per-frame offset/enable sequences are generated
// from the animation rules and compared after every frame tick.
module tb_logo_anim_ctrl;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int M  = 16;
    localparam int R  = 2;
    localparam int H  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         vsync = 1'b0;
    logic [N-1:0] hit_in = '0;
    logic [10:0]  delt;
    logic [N-1:0] letter_en;
    logic         logo_hit;
    logic         busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int d;
        int en;
        bit b;
    } exp_t;

    exp_t seq[$];
    int   last_hold;

    logo_anim_ctrl #(
        .NUM_LETTERS(N), .STEP(S), .DELT_MAX(M), .REVEAL_FRAMES(R), .HOLD_FRAMES(H)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .vsync(vsync), .hit_in(hit_in),
        .delt(delt), .letter_en(letter_en), .logo_hit(logo_hit), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int mask(input int k);
        return (1 << k) - 1;
    endfunction

    function automatic exp_t mk(input int d, input int en, input bit b);
        exp_t e;
        e.d = d; e.en = en; e.b = b;
        return e;
    endfunction

    // Expected values after each successive frame tick of one uninterrupted animation
    task automatic build_seq();
        int d;
        seq.delete();
        seq.push_back(mk(0, mask(1), 1'b1));
        for (int k = 1; k < N; k++) begin
            for (int j = 0; j < R - 1; j++) seq.push_back(mk(0, mask(k), 1'b1));
            seq.push_back(mk(0, mask(k + 1), 1'b1));
        end
        d = 0;
        while (d + S < M) begin
            d += S;
            seq.push_back(mk(d, mask(N), 1'b1));
        end
        d = M;
        seq.push_back(mk(M, mask(N), 1'b1));
        for (int j = 0; j < H; j++) seq.push_back(mk(M, mask(N), 1'b1));
        last_hold = seq.size() - 1;
        while (d > S) begin
            d -= S;
            seq.push_back(mk(d, mask(N), 1'b1));
        end
        seq.push_back(mk(0, 0, 1'b0));
    endtask

    task automatic pulse_frame();
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; vsync = 1'b0; hit_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vsync  = ~vsync;
            hit_in = N'($urandom);
            if (i > 0) begin
                tests++;
                if (delt !== 11'd0 || letter_en !== '0 || logo_hit !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_vals: delt=%0d en=%b hit=%b busy=%b, required all 0",
                             delt, letter_en, logo_hit, busy);
                end
            end
        end
        vsync = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || letter_en !== '0) begin
                fails++;
                $display("FAIL reset_release_tick: busy=%b en=%b, required 0 0", busy, letter_en);
            end
        end
        vsync = 1'b0; run = 1'b0; hit_in = '0;
        pulse_frame();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_run0: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_full_sequence();
        build_seq();
        run = 1'b1;
        for (int i = 0; i < seq.size(); i++) begin
            pulse_frame();
            tests++;
            if (delt !== 11'(seq[i].d) || letter_en !== N'(seq[i].en) || busy !== seq[i].b) begin
                fails++;
                $display("FAIL seq_tick%0d: delt=%0d en=%b busy=%b, required %0d %b %b",
                         i, delt, letter_en, busy, seq[i].d, N'(seq[i].en), seq[i].b);
            end
            @(negedge clk);
            tests++;
            if (delt !== 11'(seq[i].d) || letter_en !== N'(seq[i].en)) begin
                fails++;
                $display("FAIL seq_midframe%0d: delt=%0d en=%b, required %0d %b",
                         i, delt, letter_en, seq[i].d, N'(seq[i].en));
            end
        end
        pulse_frame();
        tests++;
        if (letter_en !== N'(1) || busy !== 1'b1 || delt !== 11'd0) begin
            fails++;
            $display("FAIL restart: en=%b busy=%b delt=%0d, required 0001 1 0", letter_en, busy, delt);
        end
        do_reset();
    endtask

    task automatic test_hit();
        logic [N-1:0] h;
        logic         e;
        run = 1'b1;
        repeat (3) pulse_frame();
        tests++;
        if (letter_en !== 4'b0011) begin
            fails++;
            $display("FAIL hit_setup: en=%b, required 0011", letter_en);
        end
        @(negedge clk) hit_in = 4'b1100;
        @(negedge clk);
        tests++;
        if (logo_hit !== 1'b0) begin
            fails++;
            $display("FAIL hit_masked: logo_hit=%b, required 0", logo_hit);
        end
        hit_in = 4'b0010;
        #1;
        tests++;
        if (logo_hit !== 1'b0) begin
            fails++;
            $display("FAIL hit_early: logo_hit=%b, required 0", logo_hit);
        end
        @(negedge clk);
        tests++;
        if (logo_hit !== 1'b1) begin
            fails++;
            $display("FAIL hit_one_clk: logo_hit=%b, required 1", logo_hit);
        end
        for (int i = 0; i < 24; i++) begin
            h = N'($urandom);
            e = |(h & 4'b0011);
            hit_in = h;
            @(negedge clk);
            tests++;
            if (logo_hit !== e) begin
                fails++;
                $display("FAIL hit_rand%0d: hit_in=%b logo_hit=%b, required %b", i, h, logo_hit, e);
            end
        end
        do_reset();
    endtask

    task automatic test_long_vsync();
        run = 1'b1;
        repeat (7) pulse_frame();
        @(negedge clk) vsync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (delt !== 11'd4) begin
                fails++;
                $display("FAIL long_vsync%0d: delt=%0d, required 4", i, delt);
            end
        end
        vsync = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (delt !== 11'd4) begin
                fails++;
                $display("FAIL long_vsync_low: delt=%0d, required 4", delt);
            end
        end
        vsync = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if (delt !== 11'd8) begin
            fails++;
            $display("FAIL long_vsync_second: delt=%0d, required 8", delt);
        end
        vsync = 1'b0;
        do_reset();
    endtask

    task automatic test_abort();
        int dexp[3] = '{8, 4, 0};
        run = 1'b1;
        repeat (9) pulse_frame();
        tests++;
        if (delt !== 11'd8 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_setup: delt=%0d busy=%b, required 8 1", delt, busy);
        end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_frame();
            tests++;
            if (delt !== 11'(dexp[i]) || busy !== (i < 2) || letter_en !== ((i < 2) ? 4'b1111 : 4'b0000)) begin
                fails++;
                $display("FAIL abort_step%0d: delt=%0d busy=%b en=%b, required %0d", i, delt, busy, letter_en, dexp[i]);
            end
        end
        run = 1'b1;
        repeat (10) pulse_frame();
        hit_in = 4'b1111;
        @(negedge clk);
        tests++;
        if (delt !== 11'd12 || logo_hit !== 1'b1) begin
            fails++;
            $display("FAIL midreset_setup: delt=%0d logo_hit=%b, required 12 1", delt, logo_hit);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (delt !== 11'd0 || letter_en !== '0 || logo_hit !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset: delt=%0d en=%b hit=%b busy=%b, required all 0",
                     delt, letter_en, logo_hit, busy);
        end
        do_reset();
    endtask

    task automatic test_random_abort();
        exp_t ex[$];
        int   k, d;
        for (int it = 0; it < 4; it++) begin
            build_seq();
            k = $urandom_range(last_hold, 1);
            ex.delete();
            for (int j = 0; j < k; j++) ex.push_back(seq[j]);
            ex.push_back(mk(seq[k-1].d, seq[k-1].en, 1'b1));
            d = seq[k-1].d;
            while (d > S) begin
                d -= S;
                ex.push_back(mk(d, seq[k-1].en, 1'b1));
            end
            ex.push_back(mk(0, 0, 1'b0));
            for (int i = 0; i < ex.size(); i++) begin
                if (i < k) run = 1'b1;
                else if (i == k || i == ex.size() - 1) run = 1'b0;
                else run = 1'($urandom);
                pulse_frame();
                tests++;
                if (delt !== 11'(ex[i].d) || letter_en !== N'(ex[i].en) || busy !== ex[i].b) begin
                    fails++;
                    $display("FAIL rabort_k%0d_t%0d: delt=%0d en=%b busy=%b, required %0d %b %b",
                             k, i, delt, letter_en, busy, ex[i].d, N'(ex[i].en), ex[i].b);
                end
            end
            do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_hit();
        test_long_vsync();
        test_abort();
        test_random_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
